// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock.
// Optional build macro BIN2BCD_SAT_EN: overflowing inputs report 9...9 instead of bin mod 10^DIGITS.
module bin2bcd_seq #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIGITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [3:0]       bcd_uni,
   output logic [3:0]       bcd_dec,
   output logic [3:0]       bcd_cent,
   output logic [3:0]       bcd_mil
);

   localparam int unsigned BW    = 4 * DIGITS;
   localparam int unsigned CW    = $clog2(WIDTH + 1);
   localparam logic [31:0] LIMIT = 32'(10 ** DIGITS);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sh;
   logic [BW-1:0]    scr;
   logic [BW-1:0]    adj;
   logic [CW-1:0]    cnt;
   logic             ovf_s;
   logic [31:0]      bin_ext;

   assign bin_ext = 32'(bin);

   // Add-3 correction on every digit in parallel before the shift.
   always_comb begin
      adj = scr;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (scr[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         sh       <= '0;
         scr      <= '0;
         cnt      <= '0;
         ovf_s    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ovf      <= 1'b0;
         bcd_uni  <= '0;
         bcd_dec  <= '0;
         bcd_cent <= '0;
         bcd_mil  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sh    <= bin;
                  scr   <= '0;
                  cnt   <= CW'(WIDTH);
                  ovf_s <= (bin_ext >= LIMIT);
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               // Bits leaving the top digit are dropped, giving bin mod 10^DIGITS.
               {scr, sh} <= {adj, sh} << 1;
               cnt       <= cnt - 1'b1;
               if (cnt == CW'(1))
                  state <= DONE;
            end
            DONE: begin
`ifdef BIN2BCD_SAT_EN
               if (ovf_s) begin
                  bcd_uni  <= 4'd9;
                  bcd_dec  <= 4'd9;
                  bcd_cent <= 4'd9;
                  bcd_mil  <= 4'd9;
               end else begin
                  bcd_uni  <= scr[3:0];
                  bcd_dec  <= scr[7:4];
                  bcd_cent <= scr[11:8];
                  bcd_mil  <= scr[15:12];
               end
`else
               bcd_uni  <= scr[3:0];
               bcd_dec  <= scr[7:4];
               bcd_cent <= scr[11:8];
               bcd_mil  <= scr[15:12];
`endif
               ovf   <= ovf_s;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
